// File: rtl/text_ram_write_arbiter.sv
// Two-requester write arbiter for the text RAM with a built-in screen-clear engine.
// Requesters use valid/ready; contention is resolved round-robin. Out-of-range
// writes are accepted and dropped, and counted in a saturating counter.
module text_ram_write_arbiter #(
  parameter int         TEXT_WIDTH  = 60,
  parameter int         TEXT_HEIGHT = 20,
  parameter int         TEXT_LEN    = TEXT_WIDTH * TEXT_HEIGHT,
  parameter int         TEXT_SZ     = $clog2(TEXT_LEN),
  parameter logic [7:0] CLEAR_CHAR  = 8'h20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               a_valid,
  input  logic [TEXT_SZ-1:0] a_addr,
  input  logic [7:0]         a_data,
  output logic               a_ready,
  input  logic               b_valid,
  input  logic [TEXT_SZ-1:0] b_addr,
  input  logic [7:0]         b_data,
  output logic               b_ready,
  input  logic               clear_start,
  output logic               clear_busy,
  output logic               clear_done,
  output logic [15:0]        drop_count,
  output logic               text_wr_ena,
  output logic [7:0]         text_wr_data,
  output logic [TEXT_SZ-1:0] text_wr_addr
);

  typedef enum logic {ARB, CLEAR} state_t;

  // Round-robin pointer encoding: which requester won the last contention.
  localparam logic GNT_A = 1'b0;
  localparam logic GNT_B = 1'b1;

  // Extra bit so the range check also works when TEXT_LEN is a power of two.
  localparam logic [TEXT_SZ:0]   LEN_X    = (TEXT_SZ+1)'(TEXT_LEN);
  localparam logic [TEXT_SZ-1:0] CLR_LAST = TEXT_SZ'(TEXT_LEN - 1);

  state_t             state_q, state_d;
  logic               last_q, last_d;
  logic [TEXT_SZ-1:0] clr_q, clr_d;
  logic               ena_q, ena_d;
  logic [7:0]         data_q, data_d;
  logic [TEXT_SZ-1:0] addr_q, addr_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [15:0]        drop_q, drop_d;

  logic [TEXT_SZ-1:0] sel_addr;
  logic [7:0]         sel_data;

  // State and registered outputs; reset aborts any clear in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ARB;
      last_q  <= GNT_B;
      clr_q   <= '0;
      ena_q   <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      clr_q   <= clr_d;
      ena_q   <= ena_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
    end
  end

  // Grant selection, write path, clear sequencing and drop accounting.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    clr_d    = clr_q;
    ena_d    = 1'b0;
    data_d   = data_q;
    addr_d   = addr_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    drop_d   = drop_q;
    a_ready  = 1'b0;
    b_ready  = 1'b0;
    sel_addr = a_addr;
    sel_data = a_data;

    case (state_q)
      ARB: begin
        if (clear_start) begin
          // Clear wins over any request this cycle; first clear write goes
          // out next cycle at address 0.
          state_d = CLEAR;
          clr_d   = '0;
          ena_d   = 1'b1;
          addr_d  = '0;
          data_d  = CLEAR_CHAR;
          busy_d  = 1'b1;
        end else begin
          if (a_valid && b_valid) begin
            // Pointer only moves on contention.
            if (last_q == GNT_B) begin
              a_ready = 1'b1;
              last_d  = GNT_A;
            end else begin
              b_ready = 1'b1;
              last_d  = GNT_B;
            end
          end else begin
            a_ready = a_valid;
            b_ready = b_valid;
          end

          if (b_ready) begin
            sel_addr = b_addr;
            sel_data = b_data;
          end

          if (a_ready || b_ready) begin
            if ({1'b0, sel_addr} < LEN_X) begin
              ena_d  = 1'b1;
              addr_d = sel_addr;
              data_d = sel_data;
            end else if (drop_q != 16'hFFFF) begin
              drop_d = drop_q + 16'd1;
            end
          end
        end
      end

      CLEAR: begin
        // clr_q is the address already on the output; clear_start is ignored.
        if (clr_q == CLR_LAST) begin
          state_d = ARB;
          done_d  = 1'b1;
        end else begin
          clr_d  = clr_q + 1'b1;
          ena_d  = 1'b1;
          addr_d = clr_q + 1'b1;
          data_d = CLEAR_CHAR;
          busy_d = 1'b1;
        end
      end

      default: state_d = ARB;
    endcase
  end

  assign text_wr_ena  = ena_q;
  assign text_wr_data = data_q;
  assign text_wr_addr = addr_q;
  assign clear_busy   = busy_q;
  assign clear_done   = done_q;
  assign drop_count   = drop_q;

endmodule

// File: tb/tb_text_ram_write_arbiter.sv
// Directed bench for text_ram_write_arbiter with a write scoreboard.
module tb_text_ram_write_arbiter;

  localparam int TEXT_LEN = 1200;
  localparam int TEXT_SZ  = 11;

  logic               clk = 1'b0;
  logic               reset;
  logic               a_valid, b_valid, clear_start;
  logic [TEXT_SZ-1:0] a_addr, b_addr;
  logic [7:0]         a_data, b_data;
  logic               a_ready, b_ready, clear_busy, clear_done;
  logic [15:0]        drop_count;
  logic               text_wr_ena;
  logic [7:0]         text_wr_data;
  logic [TEXT_SZ-1:0] text_wr_addr;

  text_ram_write_arbiter dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
    .drop_count(drop_count), .text_wr_ena(text_wr_ena),
    .text_wr_data(text_wr_data), .text_wr_addr(text_wr_addr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [TEXT_SZ-1:0] addr;
    logic [7:0]         data;
  } wr_t;

  wr_t exp_q[$];
  int  errors = 0;
  int  checks = 0;
  int  busy_cyc = 0;
  int  done_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every RAM write must match the head of the expected queue.
  always @(negedge clk) begin
    if (clear_busy) busy_cyc++;
    if (clear_done) done_cnt++;
    if (text_wr_ena === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $error("FAIL unexpected_write observed=%0h/%0h expected=none", text_wr_addr, text_wr_data);
      end else begin
        wr_t e;
        wr_t o;
        e = exp_q.pop_front();
        o = {text_wr_addr, text_wr_data};
        assert (o === e) else begin
          errors++;
          $error("FAIL ram_write observed=%0h/%0h expected=%0h/%0h",
                 o.addr, o.data, e.addr, e.data);
        end
      end
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  ai, bi, model_drop;
    bit  got, exp_a;

    reset = 1'b1; a_valid = 0; b_valid = 0; clear_start = 0;
    a_addr = '0; b_addr = '0; a_data = '0; b_data = '0;
    #1;
    chk("rst_ena", 32'(text_wr_ena), 0);
    chk("rst_addr", 32'(text_wr_addr), 0);
    chk("rst_data", 32'(text_wr_data), 0);
    chk("rst_busy", 32'(clear_busy), 0);
    chk("rst_done", 32'(clear_done), 0);
    chk("rst_drop", 32'(drop_count), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Single requester A.
    @(posedge clk); #1;
    a_valid = 1; a_addr = 11'd5; a_data = 8'h41;
    @(negedge clk);
    chk("single_a_ready", 32'(a_ready), 1);
    chk("single_b_ready", 32'(b_ready), 0);
    exp_q.push_back('{addr: 11'd5, data: 8'h41});
    @(posedge clk); #1 a_valid = 0;
    @(negedge clk);
    chk("single_ena", 32'(text_wr_ena), 1);
    chk("single_addr", 32'(text_wr_addr), 5);
    chk("single_data", 32'(text_wr_data), 32'h41);
    @(negedge clk);
    chk("single_ena_off", 32'(text_wr_ena), 0);

    // Contention: A, B, A, B.
    ai = 0; bi = 0;
    @(posedge clk); #1;
    a_valid = 1; b_valid = 1;
    for (int i = 0; i < 4; i++) begin
      a_addr = 11'(10 + ai); a_data = 8'(8'h10 + ai);
      b_addr = 11'(20 + bi); b_data = 8'(8'h80 + bi);
      @(negedge clk);
      exp_a = (i % 2 == 0);
      chk("rr_a_ready", 32'(a_ready), 32'(exp_a));
      chk("rr_b_ready", 32'(b_ready), 32'(!exp_a));
      if (exp_a) exp_q.push_back('{addr: a_addr, data: a_data});
      else       exp_q.push_back('{addr: b_addr, data: b_data});
      @(posedge clk); #1;
      if (exp_a) ai++; else bi++;
    end
    a_valid = 0; b_valid = 0;
    repeat (3) @(negedge clk);
    chk("rr_drain", 32'(exp_q.size()), 0);

    // Clear colliding with a request, plus a second start mid-clear.
    busy_cyc = 0; done_cnt = 0;
    @(posedge clk); #1;
    clear_start = 1; a_valid = 1; a_addr = 11'd7; a_data = 8'h55;
    @(negedge clk);
    chk("collide_a_ready", 32'(a_ready), 0);
    for (int k = 0; k < TEXT_LEN; k++) exp_q.push_back('{addr: 11'(k), data: 8'h20});
    exp_q.push_back('{addr: 11'd7, data: 8'h55});
    got = 0;
    for (int n = 0; n < 1300 && !got; n++) begin
      @(posedge clk); #1;
      clear_start = (n == 500);
      @(negedge clk);
      if (clear_done) begin
        chk("done_a_ready", 32'(a_ready), 1);
        got = 1;
      end else begin
        chk("clear_a_ready", 32'(a_ready), 0);
      end
    end
    chk("clear_done_seen", 32'(got), 1);
    @(posedge clk); #1 a_valid = 0;
    repeat (3) @(negedge clk);
    chk("clear_busy_cycles", 32'(busy_cyc), TEXT_LEN);
    chk("clear_done_pulses", 32'(done_cnt), 1);
    chk("clear_drain", 32'(exp_q.size()), 0);

    // Out-of-range drops.
    model_drop = 0;
    @(posedge clk); #1;
    b_valid = 1; b_addr = 11'd1200; b_data = 8'h99;
    @(negedge clk);
    chk("oor1_ready", 32'(b_ready), 1);
    model_drop++;
    @(posedge clk); #1 b_addr = 11'd2047;
    @(negedge clk);
    chk("oor2_ready", 32'(b_ready), 1);
    chk("oor1_no_write", 32'(text_wr_ena), 0);
    model_drop++;
    @(posedge clk); #1 b_valid = 0;
    @(negedge clk);
    chk("oor2_no_write", 32'(text_wr_ena), 0);
    chk("drop_two", 32'(drop_count), 32'(model_drop));

    // Drive the counter to saturation, then drop once more.
    @(posedge clk); #1 b_valid = 1;
    repeat (65533) @(posedge clk);
    #1 b_valid = 0;
    model_drop += 65533;
    @(negedge clk);
    chk("drop_full", 32'(drop_count), (model_drop > 65535) ? 65535 : model_drop);
    @(posedge clk); #1 b_valid = 1;
    @(negedge clk);
    chk("sat_ready", 32'(b_ready), 1);
    model_drop++;
    @(posedge clk); #1 b_valid = 0;
    @(negedge clk);
    chk("drop_sat", 32'(drop_count), (model_drop > 65535) ? 65535 : model_drop);

    // Reset in the middle of a clear.
    done_cnt = 0;
    @(posedge clk); #1 clear_start = 1;
    for (int k = 0; k < TEXT_LEN; k++) exp_q.push_back('{addr: 11'(k), data: 8'h20});
    @(posedge clk); #1 clear_start = 0;
    got = 0;
    for (int n = 0; n < 400 && !got; n++) begin
      @(negedge clk);
      if (text_wr_ena && text_wr_addr == 11'd300) got = 1;
    end
    chk("clear_reach_300", 32'(got), 1);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_ena", 32'(text_wr_ena), 0);
    chk("mid_rst_addr", 32'(text_wr_addr), 0);
    chk("mid_rst_data", 32'(text_wr_data), 0);
    chk("mid_rst_busy", 32'(clear_busy), 0);
    chk("mid_rst_drop", 32'(drop_count), 0);
    exp_q.delete();
    @(posedge clk); #1 reset = 1'b0;

    // First contention after reset goes to A, then B.
    @(posedge clk); #1;
    a_valid = 1; b_valid = 1;
    a_addr = 11'd100; a_data = 8'h61; b_addr = 11'd200; b_data = 8'h62;
    @(negedge clk);
    chk("post_rst_a_ready", 32'(a_ready), 1);
    chk("post_rst_b_ready", 32'(b_ready), 0);
    exp_q.push_back('{addr: 11'd100, data: 8'h61});
    @(posedge clk); #1 a_valid = 0;
    @(negedge clk);
    chk("post_rst_b_served", 32'(b_ready), 1);
    exp_q.push_back('{addr: 11'd200, data: 8'h62});
    @(posedge clk); #1 b_valid = 0;
    repeat (3) @(negedge clk);
    chk("no_done_after_rst", 32'(done_cnt), 0);
    chk("final_drain", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/text_ram_write_arbiter.md
Name: text_ram_write_arbiter

Overview:
- Shares the single write port of the text RAM (`text_wr_ena`/`_data`/`_addr`, `TEXT_SZ`-bit address) between two independent requesters, e.g. the SPI command decoder and a local console/cursor printer.
- Contains a built-in screen-clear engine that fills the whole text RAM with a fill character.
- Sits in the `clk_text_wr` domain, directly in front of the text pixel generator's write interface.

Parameters:
- `TEXT_WIDTH`, default 60: text columns.
- `TEXT_HEIGHT`, default 20: text rows.
- `TEXT_LEN`, default `TEXT_WIDTH*TEXT_HEIGHT`: character cells (1200).
- `TEXT_SZ`, default `$clog2(TEXT_LEN)`: address width (11).
- `CLEAR_CHAR`, default 8'h20: fill character written by the clear engine.

Ports:
- `clk`  in  1  text write clock (drives `clk_text_wr` of the pixel generator).
- `reset`  in  1  asynchronous, active-high reset.
- `a_valid`  in  1  requester A has a write pending.
- `a_addr`  in  `TEXT_SZ`  requester A cell address.
- `a_data`  in  8  requester A character.
- `a_ready`  out  1  requester A write accepted this cycle.
- `b_valid`  in  1  requester B has a write pending.
- `b_addr`  in  `TEXT_SZ`  requester B cell address.
- `b_data`  in  8  requester B character.
- `b_ready`  out  1  requester B write accepted this cycle.
- `clear_start`  in  1  single-cycle pulse: begin full-screen clear.
- `clear_busy`  out  1  clear engine active.
- `clear_done`  out  1  single-cycle pulse: clear finished.
- `drop_count`  out  16  saturating count of dropped out-of-range writes.
- `text_wr_ena`  out  1  to text RAM write enable.
- `text_wr_data`  out  8  to text RAM write data.
- `text_wr_addr`  out  `TEXT_SZ`  to text RAM write address.

Behaviour:
- Clocking and reset:
  - Single clock `clk`; reset is asynchronous and active-high.
  - All outputs are registered except `a_ready`/`b_ready`, which are combinational from state, valids and the round-robin pointer.
- Reset values:
  - `text_wr_ena`=0, `text_wr_data`=0, `text_wr_addr`=0.
  - `clear_busy`=0, `clear_done`=0, `drop_count`=0.
  - State=ARB; round-robin pointer `last_grant`=B, so A wins the first contention.
  - Reset asserted mid-clear aborts the clear immediately; no `clear_done` is issued.
- Handshake:
  - valid/ready; a transfer occurs on a cycle where valid && ready.
  - A requester must hold addr/data stable while valid && !ready.
  - At most one of `a_ready`/`b_ready` is high in any cycle.
- State ARB:
  - `clear_start`=1: go to CLEAR. Both readies are 0 that cycle (clear has priority over a simultaneous request).
  - Only one valid: that requester gets ready=1.
  - Both valid: grant the requester not equal to `last_grant`; `last_grant` updates to the granted requester.
  - Granted and addr < `TEXT_LEN`: next cycle `text_wr_ena`=1 with the captured addr/data (write latency 1 cycle from handshake).
  - Granted and addr >= `TEXT_LEN`: accepted (ready=1) but dropped; `text_wr_ena` stays 0; `drop_count` increments, saturating at 16'hFFFF.
  - No grant: `text_wr_ena`=0 next cycle.
- State CLEAR:
  - Internal counter `clr_addr` starts at 0. Each cycle drives `text_wr_ena`=1, `text_wr_addr`=`clr_addr`, `text_wr_data`=`CLEAR_CHAR`, then increments.
  - Writes appear on the output from the cycle after `clear_start`, one per cycle, for exactly `TEXT_LEN` cycles (addresses 0..`TEXT_LEN`-1).
  - `clear_busy`=1 from the cycle after `clear_start` through the cycle carrying the last write.
  - `a_ready`=`b_ready`=0 throughout.
  - After write `TEXT_LEN`-1: `clear_done`=1 for exactly one cycle (the cycle after the last write), `clear_busy`=0, return to ARB. Grants may resume in that same cycle.
  - `clear_start` while in CLEAR is ignored; it neither restarts nor extends the clear.
- Arithmetic:
  - `clr_addr` is `TEXT_SZ` bits; the terminal compare is against `TEXT_LEN`-1, and the counter never wraps past it.
  - `drop_count` never wraps.
- Write ordering: writes reach the RAM in handshake order. A write accepted in the cycle before `clear_start` appears before the first clear write.

Test Plan:
- Single requester: after reset, `a_valid`=1, `a_addr`=5, `a_data`=8'h41 for one cycle → `a_ready`=1 that cycle; next cycle `text_wr_ena`=1, addr 5, data 8'h41; then `text_wr_ena`=0.
- Contention: hold `a_valid` and `b_valid` high for 4 cycles with distinct data → grants go A, B, A, B; RAM sees 4 writes in that order, one per cycle.
- Clear: pulse `clear_start` → 1200 consecutive writes of 8'h20 to addresses 0..1199; `clear_busy` high for exactly 1200 cycles; `clear_done` pulses once, the cycle after address 1199. Requests held during the clear get no ready until `clear_done`.
- Clear vs. request collision: `clear_start` and `a_valid` in the same cycle → `a_ready`=0; first write out is addr 0/8'h20; A is served in the `clear_done` cycle. A second `clear_start` mid-clear → still exactly 1200 writes.
- Out-of-range: `b_addr`=1200, then 2047 → `b_ready`=1 each, no `text_wr_ena`, `drop_count`=2. Force the count to 16'hFFFF and drop once more → stays 16'hFFFF.
- Reset mid-clear: assert `reset` asynchronously at clear write 300 → outputs zero immediately without a clock edge; no `clear_done`. After release, the arbiter grants A first on contention.
